// File: rtl/packet_queue_pkg.sv
// ----------------------------------------------------------------------------
// packet_queue_pkg
//   Shared NIC definitions for the MESSAGE2PACKET queue: bus and flit widths,
//   queue depth, flit type codes, head flit field positions and the derived
//   chunk geometry (CHUNKS_PER_FLIT, MAX_CHUNKS).
//   No ports; imported by packet_queue and packet_head_builder.
// ----------------------------------------------------------------------------
package packet_queue_pkg;

  // Bus side
  localparam int BUS_DATA_WIDTH    = 16;
  localparam int BUS_ADDRESS_WIDTH = 16;

  // Network side
  localparam int FLIT_WIDTH        = 32;
  localparam int MAX_PACKET_LENGHT = 5;
  localparam int QUEUE_WIDTH       = 4;

  // Head flit layout: type code in the two MSBs, target address in the LSBs
  localparam int FLIT_TYPE_MSB         = FLIT_WIDTH - 1;
  localparam int FLIT_TYPE_LSB         = FLIT_WIDTH - 2;
  localparam int HEAD_FLIT_ADDRESS_MSB = BUS_ADDRESS_WIDTH - 1;
  localparam int HEAD_FLIT_ADDRESS_LSB = 0;

  typedef enum logic [1:0] {
    BODY_FLIT      = 2'b00,
    TAIL_FLIT      = 2'b01,
    HEAD_FLIT      = 2'b10,
    HEAD_TAIL_FLIT = 2'b11
  } flit_type_t;

  // Chunk geometry: flit 0 is the head, the remaining flits carry chunks
  localparam int CHUNKS_PER_FLIT = FLIT_WIDTH / BUS_DATA_WIDTH;
  localparam int MAX_CHUNKS      = (MAX_PACKET_LENGHT - 1) * CHUNKS_PER_FLIT;
  localparam int PACKET_WIDTH    = MAX_PACKET_LENGHT * FLIT_WIDTH;

  typedef logic [FLIT_WIDTH-1:0]                         flit_t;
  typedef logic [MAX_CHUNKS-1:0][BUS_DATA_WIDTH-1:0]     chunk_array_t;

endpackage

// File: rtl/packet_head_builder.sv
// ----------------------------------------------------------------------------
// packet_head_builder
//   Combinational head flit and flit-valid vector generator for one message.
//   Ports:
//     address   in   target address of the message
//     we        in   transaction type (1 = write)
//     count     in   number of chunks stored for the message
//     head_flit out  flit 0: type code + address, every other bit zero
//     sel       out  bit i high when flit i of the packet carries data
// ----------------------------------------------------------------------------
module packet_head_builder
  import packet_queue_pkg::*;
#(
  parameter int N_BITS_BURST_LENGHT = 7
) (
  input  logic [BUS_ADDRESS_WIDTH-1:0]   address,
  input  logic                           we,
  input  logic [N_BITS_BURST_LENGHT-1:0] count,
  output flit_t                          head_flit,
  output logic [MAX_PACKET_LENGHT-1:0]   sel
);

  // The head flit format has no field for the transaction type; it travels
  // with the slot only so a future format can pick it up here.
  logic unused_we;
  assign unused_we = we;

  // A message without chunks is a single-flit packet.
  always_comb begin
    head_flit = '0;
    head_flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB] = (count == '0) ? HEAD_TAIL_FLIT : HEAD_FLIT;
    head_flit[HEAD_FLIT_ADDRESS_MSB:HEAD_FLIT_ADDRESS_LSB] = address;
  end

  // Flit i (i >= 1) holds chunks (i-1)*CPF .. i*CPF-1, so it is valid as
  // soon as the count passes its first chunk index.
  always_comb begin
    sel    = '0;
    sel[0] = 1'b1;
    for (int i = 1; i < MAX_PACKET_LENGHT; i++) begin
      sel[i] = (count > N_BITS_BURST_LENGHT'((i - 1) * CHUNKS_PER_FLIT));
    end
  end

endmodule

// File: rtl/packet_queue.sv
// ----------------------------------------------------------------------------
// packet_queue
//   MESSAGE2PACKET queue: collects WISHBONE message chunks, assembles each
//   message into a packet slot and offers the oldest packet to the output
//   flit buffer with a request/grant handshake. QUEUE_WIDTH slots deep.
//
//   Ports:
//     clk                 in   clock, rising edge
//     rst                 in   asynchronous reset, active low
//     free_slot_o         out  a new message may start
//     chunk_valid_i       in   data_i carries a chunk
//     message_end_i       in   last beat, commits the message
//     abort_i             in   drop the message being filled
//     address_i           in   target address, sampled at message start
//     transaction_type_i  in   WE, sampled at message start
//     data_i              in   chunk data
//     out_link_o          out  packet in the head slot (flit 0 = head flit)
//     out_sel_o           out  flit valid vector of the head packet
//     r_msg_to_pkt_o      out  request: head slot holds a packet
//     g_msg_to_pkt_i      in   grant pulse, head packet consumed
//     overflow_err_o      out  (PACKET_QUEUE_OVERFLOW_ERR_EN only) sticky
//                              flag for a message longer than MAX_CHUNKS
//
//   Build option: define PACKET_QUEUE_OVERFLOW_ERR_EN to turn over-long
//   messages into discarded messages plus a sticky error flag; otherwise
//   they are silently truncated to MAX_CHUNKS.
// ----------------------------------------------------------------------------
module packet_queue
  import packet_queue_pkg::*;
#(
  parameter int N_BITS_POINTER      = 3,
  parameter int N_BITS_BURST_LENGHT = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          free_slot_o,
  input  logic                          chunk_valid_i,
  input  logic                          message_end_i,
  input  logic                          abort_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]  address_i,
  input  logic                          transaction_type_i,
  input  logic [BUS_DATA_WIDTH-1:0]     data_i,
  output logic [PACKET_WIDTH-1:0]       out_link_o,
  output logic [MAX_PACKET_LENGHT-1:0]  out_sel_o,
  output logic                          r_msg_to_pkt_o,
  input  logic                          g_msg_to_pkt_i
`ifdef PACKET_QUEUE_OVERFLOW_ERR_EN
  ,
  output logic                          overflow_err_o
`endif
);

  localparam int DEPTH = 2 ** N_BITS_POINTER;

  localparam logic [N_BITS_POINTER-1:0]      LAST_SLOT = N_BITS_POINTER'(QUEUE_WIDTH - 1);
  localparam logic [N_BITS_BURST_LENGHT-1:0] COUNT_MAX = N_BITS_BURST_LENGHT'(MAX_CHUNKS);
  localparam logic [N_BITS_BURST_LENGHT-1:0] COUNT_ONE = N_BITS_BURST_LENGHT'(1);
  localparam logic [N_BITS_POINTER-1:0]      PTR_ONE   = N_BITS_POINTER'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  // Control state
  logic [0:0]                     state;
  logic [N_BITS_POINTER-1:0]      head;
  logic [N_BITS_POINTER-1:0]      tail;
  logic [N_BITS_BURST_LENGHT-1:0] count;
  logic [DEPTH-1:0]               valid_bit_r;

  // Header of the message being filled (belongs to the tail slot)
  logic [BUS_ADDRESS_WIDTH-1:0]   msg_addr;
  logic                           msg_we;

  // Slot storage, deliberately not reset
  chunk_array_t                   slot_data [DEPTH];
  flit_t                          slot_head [DEPTH];
  logic [MAX_PACKET_LENGHT-1:0]   slot_sel  [DEPTH];

  // Per-cycle decisions
  logic                           start_beat;
  logic                           accept;
  logic                           wr_chunk;
  logic                           end_msg;
  logic                           commit;
  logic                           grant_ok;
  logic [N_BITS_BURST_LENGHT-1:0] count_with_chunk;
  logic [BUS_ADDRESS_WIDTH-1:0]   hdr_addr;
  logic                           hdr_we;
  flit_t                          built_head;
  logic [MAX_PACKET_LENGHT-1:0]   built_sel;

  function automatic logic [N_BITS_POINTER-1:0] next_ptr(input logic [N_BITS_POINTER-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_ONE;
  endfunction

  // In IDLE a beat only counts when the tail slot is free; once FILL has
  // reserved the slot every beat is taken unless an abort overrides it.
  assign free_slot_o      = (state == IDLE) && !valid_bit_r[tail];
  assign start_beat       = free_slot_o && (chunk_valid_i || message_end_i);
  assign accept           = (state == IDLE) ? start_beat : !abort_i;
  assign wr_chunk         = accept && chunk_valid_i && (count < COUNT_MAX);
  assign end_msg          = accept && message_end_i;
  assign count_with_chunk = wr_chunk ? (count + COUNT_ONE) : count;
  assign grant_ok         = g_msg_to_pkt_i && valid_bit_r[head];

`ifdef PACKET_QUEUE_OVERFLOW_ERR_EN
  logic msg_overflow;
  logic overflow_now;

  // A chunk past the last position poisons the whole message.
  assign overflow_now = accept && chunk_valid_i && (count == COUNT_MAX);
  assign commit       = end_msg && !(msg_overflow || overflow_now);
`else
  assign commit       = end_msg;
`endif

  // On a same-cycle start+end the header has not been registered yet, so the
  // head flit is built straight from the bus.
  assign hdr_addr = (state == IDLE) ? address_i : msg_addr;
  assign hdr_we   = (state == IDLE) ? transaction_type_i : msg_we;

  packet_head_builder #(
    .N_BITS_BURST_LENGHT (N_BITS_BURST_LENGHT)
  ) u_head_builder (
    .address   (hdr_addr),
    .we        (hdr_we),
    .count     (count_with_chunk),
    .head_flit (built_head),
    .sel       (built_sel)
  );

  // Queue pointers, valid bits and the fill FSM. Grant and commit may land
  // on the same edge; they touch different slots, so both simply apply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      valid_bit_r <= '0;
    end else begin
      if (grant_ok) begin
        valid_bit_r[head] <= 1'b0;
        head              <= next_ptr(head);
      end
      if (commit) begin
        valid_bit_r[tail] <= 1'b1;
        tail              <= next_ptr(tail);
      end
      if ((state == FILL) && abort_i) begin
        count <= '0;
        state <= IDLE;
      end else if (end_msg) begin
        count <= '0;
        state <= IDLE;
      end else if (accept) begin
        count <= count_with_chunk;
        state <= FILL;
      end
    end
  end

`ifdef PACKET_QUEUE_OVERFLOW_ERR_EN
  // Per-message poison bit plus the sticky error output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_overflow   <= 1'b0;
      overflow_err_o <= 1'b0;
    end else begin
      if (overflow_now) begin
        overflow_err_o <= 1'b1;
      end
      if (((state == FILL) && abort_i) || end_msg) begin
        msg_overflow <= 1'b0;
      end else if (overflow_now) begin
        msg_overflow <= 1'b1;
      end
    end
  end
`endif

  // Slot payload: header capture at message start, chunk writes at the
  // current count, head flit and sel frozen at commit.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start_beat) begin
      msg_addr <= address_i;
      msg_we   <= transaction_type_i;
    end
    if (wr_chunk) begin
      for (int k = 0; k < MAX_CHUNKS; k++) begin
        if (count == N_BITS_BURST_LENGHT'(k)) begin
          slot_data[tail][k] <= data_i;
        end
      end
    end
    if (commit) begin
      slot_head[tail] <= built_head;
      slot_sel[tail]  <= built_sel;
    end
  end

  // The link is blanked whenever there is nothing to offer.
  assign r_msg_to_pkt_o = valid_bit_r[head];
  assign out_link_o     = r_msg_to_pkt_o ? {slot_data[head], slot_head[head]} : '0;
  assign out_sel_o      = r_msg_to_pkt_o ? slot_sel[head] : '0;

endmodule

// File: tb/tb_packet_queue.sv
// ----------------------------------------------------------------------------
// tb_packet_queue
//   Self-checking bench for packet_queue. Message vectors come from a table;
//   each committed message pushes its expected packet onto a scoreboard that
//   is popped when the DUT raises its request.
//   Build option: PACKET_QUEUE_OVERFLOW_ERR_EN (must match the DUT build).
// ----------------------------------------------------------------------------
module tb_packet_queue;
  import packet_queue_pkg::*;

  typedef struct {
    logic [BUS_ADDRESS_WIDTH-1:0] addr;
    logic                         we;
    int                           n;
    logic [MAX_PACKET_LENGHT-1:0] sel;
    logic [1:0]                   ftype;
  } vec_t;

  typedef struct {
    logic [BUS_ADDRESS_WIDTH-1:0] addr;
    int                           n;
    logic [MAX_PACKET_LENGHT-1:0] sel;
    logic [1:0]                   ftype;
    chunk_array_t                 chunks;
  } exp_t;

  logic                          clk;
  logic                          rst;
  logic                          free_slot_o;
  logic                          chunk_valid_i;
  logic                          message_end_i;
  logic                          abort_i;
  logic [BUS_ADDRESS_WIDTH-1:0]  address_i;
  logic                          transaction_type_i;
  logic [BUS_DATA_WIDTH-1:0]     data_i;
  logic [PACKET_WIDTH-1:0]       out_link_o;
  logic [MAX_PACKET_LENGHT-1:0]  out_sel_o;
  logic                          r_msg_to_pkt_o;
  logic                          g_msg_to_pkt_i;
`ifdef PACKET_QUEUE_OVERFLOW_ERR_EN
  logic                          overflow_err_o;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t scoreboard[$];
  vec_t vecs[7];

  packet_queue dut (
    .clk                (clk),
    .rst                (rst),
    .free_slot_o        (free_slot_o),
    .chunk_valid_i      (chunk_valid_i),
    .message_end_i      (message_end_i),
    .abort_i            (abort_i),
    .address_i          (address_i),
    .transaction_type_i (transaction_type_i),
    .data_i             (data_i),
    .out_link_o         (out_link_o),
    .out_sel_o          (out_sel_o),
    .r_msg_to_pkt_o     (r_msg_to_pkt_o),
    .g_msg_to_pkt_i     (g_msg_to_pkt_i)
`ifdef PACKET_QUEUE_OVERFLOW_ERR_EN
    ,
    .overflow_err_o     (overflow_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  task automatic idleInputs();
    chunk_valid_i  = 1'b0;
    message_end_i  = 1'b0;
    abort_i        = 1'b0;
    g_msg_to_pkt_i = 1'b0;
    data_i         = '0;
  endtask

  // Drives one message starting at a negedge; the address is scrambled after
  // the first beat so only the start-of-message sample can be used.
  task automatic sendMessage(input logic [BUS_ADDRESS_WIDTH-1:0] addr, input logic we,
                             input int n, input bit withEnd, input bit grantOnEnd,
                             output chunk_array_t sent);
    int waited = 0;
    logic [BUS_DATA_WIDTH-1:0] d;
    sent = '0;
    while (!free_slot_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!free_slot_o) begin
      timeoutFail("free_slot_wait");
      return;
    end
    address_i          = addr;
    transaction_type_i = we;
    if (n == 0) begin
      message_end_i  = withEnd;
      g_msg_to_pkt_i = grantOnEnd;
      @(negedge clk);
    end else begin
      for (int k = 0; k < n; k++) begin
        d             = BUS_DATA_WIDTH'($urandom);
        chunk_valid_i = 1'b1;
        data_i        = d;
        message_end_i = withEnd && (k == n - 1);
        if (k == n - 1) g_msg_to_pkt_i = grantOnEnd;
        if (k < MAX_CHUNKS) sent[k] = d;
        @(negedge clk);
        address_i = ~addr;
      end
    end
    idleInputs();
  endtask

  task automatic applyStimulus(input vec_t v, input bit grantOnEnd);
    exp_t e;
    chunk_array_t s;
    sendMessage(v.addr, v.we, v.n, 1'b1, grantOnEnd, s);
    e.addr   = v.addr;
    e.n      = (v.n > MAX_CHUNKS) ? MAX_CHUNKS : v.n;
    e.sel    = v.sel;
    e.ftype  = v.ftype;
    e.chunks = s;
    scoreboard.push_back(e);
  endtask

  // Pops the oldest expectation, compares the head packet and optionally
  // grants it for one cycle.
  task automatic checkOutput(input bit doGrant);
    exp_t e;
    int waited = 0;
    if (scoreboard.size() == 0) begin
      timeoutFail("scoreboard_empty");
      return;
    end
    e = scoreboard.pop_front();
    while (!r_msg_to_pkt_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!r_msg_to_pkt_o) begin
      timeoutFail("request_wait");
      return;
    end
    checkVal("head_type", 32'(out_link_o[FLIT_TYPE_MSB:FLIT_TYPE_LSB]), 32'(e.ftype));
    checkVal("head_addr", 32'(out_link_o[HEAD_FLIT_ADDRESS_MSB:HEAD_FLIT_ADDRESS_LSB]), 32'(e.addr));
    checkVal("head_pad", 32'(out_link_o[FLIT_TYPE_LSB-1:BUS_ADDRESS_WIDTH]), 32'd0);
    checkVal("sel", 32'(out_sel_o), 32'(e.sel));
    for (int k = 0; k < e.n; k++) begin
      checkVal($sformatf("chunk%0d", k),
               32'(out_link_o[FLIT_WIDTH + k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]),
               32'(e.chunks[k]));
    end
    if (doGrant) begin
      g_msg_to_pkt_i = 1'b1;
      @(negedge clk);
      g_msg_to_pkt_i = 1'b0;
    end
  endtask

  initial begin
    chunk_array_t scratch;

    vecs[0] = '{16'h0040, 1'b0,  0, 5'b00001, HEAD_TAIL_FLIT};
    vecs[1] = '{16'h1234, 1'b1,  3, 5'b00111, HEAD_FLIT};
    vecs[2] = '{16'h00A5, 1'b1,  1, 5'b00011, HEAD_FLIT};
    vecs[3] = '{16'h7F00, 1'b1,  4, 5'b00111, HEAD_FLIT};
    vecs[4] = '{16'hBEEF, 1'b1,  8, 5'b11111, HEAD_FLIT};
    vecs[5] = '{16'h0001, 1'b0,  5, 5'b01111, HEAD_FLIT};
    vecs[6] = '{16'h0ABC, 1'b1, 10, 5'b11111, HEAD_FLIT};

    rst                = 1'b0;
    address_i          = '0;
    transaction_type_i = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);

    // Reset values
    checkVal("rst_free_slot", 32'(free_slot_o), 32'd1);
    checkVal("rst_request", 32'(r_msg_to_pkt_o), 32'd0);
    checkVal("rst_link_zero", 32'(out_link_o != '0), 32'd0);
    checkVal("rst_sel", 32'(out_sel_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table: one message at a time, granted and drained
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], 1'b0);
      checkOutput(1'b1);
      checkVal("drained_request", 32'(r_msg_to_pkt_o), 32'd0);
      checkVal("drained_link_zero", 32'(out_link_o != '0), 32'd0);
    end

    // Full queue: four messages, a refused beat, one grant, wrap-around
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b0);
    checkVal("full_free_slot", 32'(free_slot_o), 32'd0);
    address_i     = 16'hDEAD;
    chunk_valid_i = 1'b1;
    message_end_i = 1'b1;
    data_i        = 16'h5555;
    @(negedge clk);
    idleInputs();
    checkVal("full_ignored_beat", 32'(free_slot_o), 32'd0);
    checkOutput(1'b1);
    checkVal("reopen_free_slot", 32'(free_slot_o), 32'd1);
    applyStimulus(vecs[5], 1'b0);
    for (int i = 0; i < 4; i++) checkOutput(1'b1);
    checkVal("full_drained_request", 32'(r_msg_to_pkt_o), 32'd0);

    // Abort mid-message, abort and grant while idle, then a fresh message
    sendMessage(16'h2222, 1'b1, 2, 1'b0, 1'b0, scratch);
    checkVal("fill_free_slot", 32'(free_slot_o), 32'd0);
    abort_i = 1'b1;
    @(negedge clk);
    idleInputs();
    checkVal("abort_free_slot", 32'(free_slot_o), 32'd1);
    checkVal("abort_request", 32'(r_msg_to_pkt_o), 32'd0);
    abort_i        = 1'b1;
    g_msg_to_pkt_i = 1'b1;
    @(negedge clk);
    idleInputs();
    checkVal("idle_abort_free_slot", 32'(free_slot_o), 32'd1);
    applyStimulus(vecs[2], 1'b0);
    checkOutput(1'b1);
    checkVal("abort_drained_request", 32'(r_msg_to_pkt_o), 32'd0);

    // Commit and grant on the same edge with two packets queued
    applyStimulus(vecs[2], 1'b0);
    applyStimulus(vecs[3], 1'b0);
    checkOutput(1'b0);
    applyStimulus(vecs[1], 1'b1);
    checkOutput(1'b1);
    checkOutput(1'b1);
    checkVal("cg_drained_request", 32'(r_msg_to_pkt_o), 32'd0);

    // Over-long message
`ifdef PACKET_QUEUE_OVERFLOW_ERR_EN
    checkVal("ovf_err_before", 32'(overflow_err_o), 32'd0);
    sendMessage(vecs[6].addr, vecs[6].we, vecs[6].n, 1'b1, 1'b0, scratch);
    repeat (2) @(negedge clk);
    checkVal("ovf_err_set", 32'(overflow_err_o), 32'd1);
    checkVal("ovf_nothing_queued", 32'(r_msg_to_pkt_o), 32'd0);
    checkVal("ovf_free_slot", 32'(free_slot_o), 32'd1);
`else
    applyStimulus(vecs[6], 1'b0);
    checkOutput(1'b1);
    checkVal("ovf_drained_request", 32'(r_msg_to_pkt_o), 32'd0);
`endif

    // Asynchronous reset while filling, with one packet pending
    applyStimulus(vecs[3], 1'b0);
    sendMessage(16'h3333, 1'b1, 2, 1'b0, 1'b0, scratch);
    checkVal("pre_rst_request", 32'(r_msg_to_pkt_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkVal("async_rst_free_slot", 32'(free_slot_o), 32'd1);
    checkVal("async_rst_request", 32'(r_msg_to_pkt_o), 32'd0);
    checkVal("async_rst_link_zero", 32'(out_link_o != '0), 32'd0);
    checkVal("async_rst_sel", 32'(out_sel_o), 32'd0);
`ifdef PACKET_QUEUE_OVERFLOW_ERR_EN
    checkVal("async_rst_ovf_err", 32'(overflow_err_o), 32'd0);
`endif
    scoreboard.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[1], 1'b0);
    checkOutput(1'b1);
    checkVal("post_rst_request", 32'(r_msg_to_pkt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
